// File: rtl/scan_mux.sv
// Registered N:1 multiplexer with manual select or round-robin dwell scanning.
// Define SCAN_MASK_EN to add en_mask, which restricts which channels the scan visits.
module scan_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] X,
    input  logic [SEL_W-1:0]          C,
    input  logic                      mode,
    input  logic                      hold,
`ifdef SCAN_MASK_EN
    input  logic [CHANNELS-1:0]       en_mask,
`endif
    output logic [WIDTH-1:0]          Y,
    output logic [SEL_W-1:0]          ch,
    output logic                      new_ch,
    output logic                      sel_err
);

    localparam int                CNT_W      = $clog2(DWELL) + 1;
    localparam logic [SEL_W:0]    CH_LIM     = (SEL_W + 1)'(CHANNELS);
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               new_ch_q, new_ch_d;
    logic               sel_err_q, sel_err_d;

    logic [SEL_W-1:0]   adv_s;
    logic               adv_blank_s;
    logic [CNT_W-1:0]   cnt_cur_s;
    logic               blank_s;
    logic               c_ok_s;

`ifdef SCAN_MASK_EN
    logic [SEL_W:0]     cand_s;

    // Next enabled channel after ch in circular order; larger distances are overwritten by nearer ones.
    always_comb begin
        adv_s       = ch_q;
        adv_blank_s = 1'b1;
        cand_s      = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            cand_s = {1'b0, ch_q} + (SEL_W + 1)'(i);
            if (cand_s >= CH_LIM) begin
                cand_s = cand_s - CH_LIM;
            end else begin
                cand_s = cand_s;
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if ((cand_s == (SEL_W + 1)'(k)) && en_mask[k]) begin
                    adv_s       = SEL_W'(k);
                    adv_blank_s = 1'b0;
                end else begin
                    adv_s       = adv_s;
                end
            end
        end
    end
`else
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    // Plain round-robin successor, wrapped by compare rather than by overflow.
    always_comb begin
        adv_blank_s = 1'b0;
        if (ch_q == LAST_CH) begin
            adv_s = '0;
        end else begin
            adv_s = ch_q + SEL_W'(1);
        end
    end
`endif

    // Next-channel selection, dwell counting and the data/flag values to register.
    always_comb begin
        state_d   = mode ? SCAN : MANUAL;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        sel_err_d = sel_err_q;
        blank_s   = 1'b0;
        c_ok_s    = ({1'b0, C} < CH_LIM);
        // A freshly entered scan always starts its dwell from zero.
        cnt_cur_s = (state_q == SCAN) ? cnt_q : '0;

        if (hold) begin
            ch_d = ch_q;
        end else if (!mode) begin
            cnt_d = '0;
            if (c_ok_s) begin
                ch_d      = C;
                sel_err_d = 1'b0;
            end else begin
                ch_d      = ch_q;
                blank_s   = 1'b1;
                sel_err_d = 1'b1;
            end
        end else begin
            sel_err_d = 1'b0;
            if (cnt_cur_s == DWELL_LAST) begin
                cnt_d   = '0;
                ch_d    = adv_s;
                blank_s = adv_blank_s;
            end else begin
                cnt_d = cnt_cur_s + CNT_ONE;
            end
        end

        y_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!blank_s && (ch_d == SEL_W'(k))) begin
                y_d = X[k*WIDTH +: WIDTH];
            end else begin
                y_d = y_d;
            end
        end

        new_ch_d = hold ? 1'b0 : (ch_d != ch_q);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MANUAL;
            cnt_q     <= '0;
            ch_q      <= '0;
            y_q       <= '0;
            new_ch_q  <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            y_q       <= y_d;
            new_ch_q  <= new_ch_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign Y       = y_q;
    assign ch      = ch_q;
    assign new_ch  = new_ch_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: a 4-channel and a 3-channel instance (DWELL=3)
// compared every cycle against a behavioural model, plus directed literal checks.
module tb_scan_mux;

    localparam int DW = 3;

    logic        clk;
    logic        reset;
    logic [15:0] x_bus;
    logic [1:0]  c_sel;
    logic        mode;
    logic        hold;
    logic [3:0]  en_mask0;

    logic [3:0]  y0, y1;
    logic [1:0]  ch0, ch1;
    logic        nc0, nc1;
    logic        err0, err1;

    int checks = 0;
    int errors = 0;

    int   m_ch  [2];
    int   m_cnt [2];
    int   m_y   [2];
    int   m_new [2];
    int   m_err [2];
    bit   started = 0;

    scan_mux #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(DW)) dut4 (
        .clk(clk), .reset(reset), .X(x_bus), .C(c_sel), .mode(mode), .hold(hold),
`ifdef SCAN_MASK_EN
        .en_mask(en_mask0),
`endif
        .Y(y0), .ch(ch0), .new_ch(nc0), .sel_err(err0)
    );

    scan_mux #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(DW)) dut3 (
        .clk(clk), .reset(reset), .X(x_bus[11:0]), .C(c_sel), .mode(mode), .hold(hold),
`ifdef SCAN_MASK_EN
        .en_mask(3'b111),
`endif
        .Y(y1), .ch(ch1), .new_ch(nc1), .sel_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int chan(input int k);
        return int'(x_bus[k*4 +: 4]);
    endfunction

    // Behavioural model: one step of the selection rules for instance i.
    task automatic model_step(input int i);
        int nch;
        int nx;
        bit found;
        logic [3:0] m;
        nch = (i == 0) ? 4 : 3;
        m   = (i == 0) ? en_mask0 : 4'b0111;
        if (reset) begin
            m_ch[i] = 0; m_cnt[i] = 0; m_y[i] = 0; m_new[i] = 0; m_err[i] = 0;
        end else if (hold) begin
            m_new[i] = 0;
            m_y[i]   = chan(m_ch[i]);
        end else if (!mode) begin
            m_cnt[i] = 0;
            if (int'(c_sel) < nch) begin
                m_new[i] = (int'(c_sel) != m_ch[i]);
                m_ch[i]  = int'(c_sel);
                m_y[i]   = chan(m_ch[i]);
                m_err[i] = 0;
            end else begin
                m_new[i] = 0;
                m_y[i]   = 0;
                m_err[i] = 1;
            end
        end else begin
            m_err[i] = 0;
            if (m_cnt[i] + 1 >= DW) begin
                m_cnt[i] = 0;
                found = 0;
                nx = m_ch[i];
                for (int d = 1; d <= nch; d++) begin
                    if (!found && m[(m_ch[i] + d) % nch]) begin
                        found = 1;
                        nx = (m_ch[i] + d) % nch;
                    end
                end
                if (found) begin
                    m_new[i] = (nx != m_ch[i]);
                    m_ch[i]  = nx;
                    m_y[i]   = chan(nx);
                end else begin
                    m_new[i] = 0;
                    m_y[i]   = 0;
                end
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
                m_new[i] = 0;
                m_y[i]   = chan(m_ch[i]);
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_y4",   int'(y0),   m_y[0]);
            chk("model_ch4",  int'(ch0),  m_ch[0]);
            chk("model_new4", int'(nc0),  m_new[0]);
            chk("model_err4", int'(err0), m_err[0]);
            chk("model_y3",   int'(y1),   m_y[1]);
            chk("model_ch3",  int'(ch1),  m_ch[1]);
            chk("model_new3", int'(nc1),  m_new[1]);
            chk("model_err3", int'(err1), m_err[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int scan_ch [15] = '{3, 3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    int scan_y  [4]  = '{4'hA, 4'hB, 4'hC, 4'hD};
`ifdef SCAN_MASK_EN
    int mask_ch [9]  = '{1, 1, 3, 3, 3, 1, 1, 1, 3};
`endif

    initial begin
        reset = 1'b1; mode = 1'b1; hold = 1'b0; c_sel = 2'd0;
        x_bus = 16'hDCBA; en_mask0 = 4'hF;

        tick(); tick();
        chk("rst_y", int'(y0), 0);
        chk("rst_ch", int'(ch0), 0);
        chk("rst_new", int'(nc0), 0);
        chk("rst_err", int'(err0), 0);

        reset = 1'b0;
        tick();
        chk("release_y", int'(y0), 4'hA);
        chk("release_ch", int'(ch0), 0);

        mode = 1'b0; c_sel = 2'd2;
        tick();
        chk("man_y", int'(y0), 4'hC);
        chk("man_ch", int'(ch0), 2);
        chk("man_new", int'(nc0), 1);
        x_bus[11:8] = 4'h5;
        tick();
        chk("live_y", int'(y0), 4'h5);
        chk("live_new", int'(nc0), 0);
        x_bus = 16'hDCBA;

        c_sel = 2'd3;
        tick();
        chk("man3_ch", int'(ch0), 3);
        chk("oor_dut3_y", int'(y1), 0);
        chk("oor_dut3_err", int'(err1), 1);
        chk("oor_dut3_ch", int'(ch1), 2);

        mode = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            tick();
            chk("scan_ch", int'(ch0), scan_ch[t-1]);
            chk("scan_y", int'(y0), scan_y[scan_ch[t-1]]);
            chk("scan_new", int'(nc0), (t % 3 == 0) ? 1 : 0);
        end

        for (int t = 0; t < 4; t++) tick();
        chk("pre_hold_ch", int'(ch0), 1);
        hold = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("hold_ch", int'(ch0), 1);
            chk("hold_new", int'(nc0), 0);
            chk("hold_y", int'(y0), 4'hB);
        end
        hold = 1'b0;
        tick();
        chk("post_hold1_ch", int'(ch0), 1);
        tick();
        chk("post_hold2_ch", int'(ch0), 2);
        chk("post_hold2_new", int'(nc0), 1);

        mode = 1'b0; c_sel = 2'd1;
        tick();
        chk("oor_pre_y", int'(y1), 4'hB);
        c_sel = 2'd3;
        tick();
        chk("oor_y", int'(y1), 0);
        chk("oor_ch", int'(ch1), 1);
        chk("oor_err", int'(err1), 1);
        hold = 1'b1; c_sel = 2'd1;
        tick();
        chk("oor_hold_err", int'(err1), 1);
        chk("oor_hold_y", int'(y1), 4'hB);
        hold = 1'b0;
        tick();
        chk("oor_clear_y", int'(y1), 4'hB);
        chk("oor_clear_err", int'(err1), 0);

        mode = 1'b1;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("midrst_ch", int'(ch0), 0);
        chk("midrst_y", int'(y0), 0);
        reset = 1'b0; mode = 1'b0; c_sel = 2'd0;
        tick();

`ifdef SCAN_MASK_EN
        en_mask0 = 4'b1010; c_sel = 2'd1;
        tick();
        mode = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            chk("mask_ch", int'(ch0), mask_ch[t-1]);
        end
        en_mask0 = 4'b0000;
        tick(); tick();
        chk("mask0_pre_y", int'(y0), 4'hD);
        tick();
        chk("mask0_ch", int'(ch0), 3);
        chk("mask0_y", int'(y0), 0);
        chk("mask0_new", int'(nc0), 0);
        tick();
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
